// File: rtl/conv_window_gen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : conv_window_gen_pkg                                        |
// | Description : Shared constants and FSM state type for the window gen.   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package conv_window_gen_pkg;

    localparam int DEF_IMG_W  = 28;
    localparam int DEF_IMG_H  = 28;
    localparam int DEF_K      = 5;
    localparam int PIX_W      = 8;
    localparam int DEF_ADDR_W = 10;
    localparam int NUM_WIN    = (DEF_IMG_W - DEF_K + 1) * (DEF_IMG_H - DEF_K + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/conv_window_gen_line_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : conv_line_buffer                                           |
// | Description : K-1 chained IMG_W-deep pixel shift rows with one tap each. |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module conv_line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 28,
    parameter int K          = 5
) (
    input  logic                          clk,
    input  logic                          shift_en,
    input  logic [DATA_WIDTH-1:0]         din,
    output logic [(K-1)*DATA_WIDTH-1:0]   taps
);

    logic [DATA_WIDTH-1:0] mem_q  [K-1][IMG_W];
    logic [DATA_WIDTH-1:0] mem_d  [K-1][IMG_W];
    logic [DATA_WIDTH-1:0] seg_in [K-1];

    // Row K-2 holds the previous image row; row 0 is the oldest (K-1 rows back).
    for (genvar j = 0; j < K-1; j++) begin : g_seg
        if (j == K-2) begin : g_head
            assign seg_in[j] = din;
        end else begin : g_link
            assign seg_in[j] = mem_q[j+1][IMG_W-1];
        end
        assign taps[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[j][IMG_W-1];
    end

    always_comb begin
        mem_d = mem_q;
        if (shift_en) begin
            for (int j = 0; j < K-1; j++) begin
                mem_d[j][0] = seg_in[j];
                for (int i = 1; i < IMG_W; i++) begin
                    mem_d[j][i] = mem_q[j][i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : conv_window_gen                                            |
// | Description : Reads an image from RAM port B and streams KxK windows.    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int DATA_WIDTH = PIX_W,
    parameter int ADDR_WIDTH = DEF_ADDR_W,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int K          = DEF_K
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          enb,
    output logic [ADDR_WIDTH-1:0]         addrb,
    input  logic [DATA_WIDTH-1:0]         doutb,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [K*K*DATA_WIDTH-1:0]     out_window
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_W*IMG_H - 1);

    state_e                 state_q,      state_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q,    rd_addr_d;
    logic                   rd_pend_q,    rd_pend_d;
    logic                   hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0]  hold_q,       hold_d;
    logic [COL_W-1:0]       col_q,        col_d;
    logic [ROW_W-1:0]       row_q,        row_d;
    logic                   out_valid_q,  out_valid_d;
    logic                   last_pix_q,   last_pix_d;
    logic                   done_q,       done_d;
    logic [DATA_WIDTH-1:0]  win_q [K][K];
    logic [DATA_WIDTH-1:0]  win_d [K][K];

    logic                          step;
    logic                          pix_avail;
    logic                          do_shift;
    logic                          issue;
    logic [DATA_WIDTH-1:0]         pix;
    logic [(K-1)*DATA_WIDTH-1:0]   taps;
    logic [DATA_WIDTH-1:0]         col_in [K];

    // The hold register always carries the older pixel, so it wins over doutb.
    assign step      = !out_valid_q || out_ready;
    assign pix_avail = hold_valid_q || rd_pend_q;
    assign pix       = hold_valid_q ? hold_q : doutb;
    assign do_shift  = step && pix_avail;
    assign issue     = (state_q == ST_RUN) && step && !hold_valid_q;

    assign enb       = issue;
    assign addrb     = rd_addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign out_valid = out_valid_q;

    conv_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMG_W      (IMG_W),
        .K          (K)
    ) u_line_buffer (
        .clk      (clk),
        .shift_en (do_shift),
        .din      (pix),
        .taps     (taps)
    );

    for (genvar r = 0; r < K; r++) begin : g_col_in
        if (r < K-1) begin : g_tap
            assign col_in[r] = taps[r*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_new
            assign col_in[r] = pix;
        end
        for (genvar c = 0; c < K; c++) begin : g_out
            assign out_window[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        rd_pend_d    = issue;
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        col_d        = col_q;
        row_d        = row_q;
        out_valid_d  = out_valid_q;
        last_pix_d   = last_pix_q;
        done_d       = 1'b0;
        win_d        = win_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    rd_addr_d  = '0;
                    col_d      = '0;
                    row_d      = '0;
                    last_pix_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    rd_addr_d = rd_addr_q + 1'b1;
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready && last_pix_q) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    rd_addr_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // RAM data that arrives during a stall would be lost without the hold reg.
        if (rd_pend_q && !step) begin
            hold_valid_d = 1'b1;
            hold_d       = doutb;
        end else if (hold_valid_q && step) begin
            hold_valid_d = 1'b0;
        end

        if (do_shift) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K-1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][K-1] = col_in[r];
            end
            out_valid_d = (row_q >= ROW_W'(K-1)) && (col_q >= COL_W'(K-1));
            last_pix_d  = (row_q == ROW_W'(IMG_H-1)) && (col_q == COL_W'(IMG_W-1));
            if (col_q == COL_W'(IMG_W-1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(IMG_H-1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end else if (step) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rd_addr_q    <= '0;
            rd_pend_q    <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            last_pix_q   <= 1'b0;
            done_q       <= 1'b0;
            win_q        <= '{default: '0};
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            rd_pend_q    <= rd_pend_d;
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            last_pix_q   <= last_pix_d;
            done_q       <= done_d;
            win_q        <= win_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_conv_window_gen                                         |
// | Description : Self-checking bench with RAM model and window reference.   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_conv_window_gen;

    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int W     = 28;
    localparam int H     = 28;
    localparam int K     = 5;
    localparam int NPIX  = W * H;
    localparam int WPR   = W - K + 1;
    localparam int NW    = WPR * (H - K + 1);
    localparam int WIN_W = K * K * DW;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             out_ready = 1'b1;
    logic             busy, done, enb, out_valid;
    logic [AW-1:0]    addrb;
    logic [DW-1:0]    doutb = '0;
    logic [WIN_W-1:0] out_window;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_window_gen #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .IMG_W      (W),
        .IMG_H      (H),
        .K          (K)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .enb        (enb),
        .addrb      (addrb),
        .doutb      (doutb),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_window (out_window)
    );

    logic [DW-1:0] img [NPIX];

    always @(posedge clk) begin
        if (enb) doutb <= (int'(addrb) < NPIX) ? img[addrb] : '0;
    end

    // Monitor: logs reads, handshakes and per-frame timing marks.
    int               cyc = 0;
    int               t_start = 0, first_enb_cyc = -1, first_valid_cyc = -1;
    int               done_cyc = -1, busy_fall_cyc = -1;
    int               done_cnt = 0, stall_err = 0, valid_cnt = 0;
    logic             prev_busy = 1'b0, prev_stall = 1'b0;
    logic [WIN_W-1:0] prev_win = '0;
    logic [WIN_W-1:0] win_log [$];
    int               addr_log [$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            prev_busy  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                t_start         = cyc - 1;
                first_enb_cyc   = -1;
                first_valid_cyc = -1;
            end
            if (!busy && prev_busy) busy_fall_cyc = cyc;
            prev_busy = busy;
            if (enb) begin
                if (first_enb_cyc < 0) first_enb_cyc = cyc;
                addr_log.push_back(int'(addrb));
            end
            if (out_valid) begin
                valid_cnt = valid_cnt + 1;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (out_valid && out_ready) win_log.push_back(out_window);
            if (prev_stall && (!out_valid || out_window !== prev_win)) stall_err = stall_err + 1;
            prev_stall = out_valid && !out_ready;
            prev_win   = out_window;
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    int win_base = 0, addr_base = 0, done_base = 0, stall_base = 0, valid_base = 0;

    function automatic logic [WIN_W-1:0] exp_window(input int n);
        logic [WIN_W-1:0] w;
        int wr, wc;
        wr = n / WPR;
        wc = n % WPR;
        w  = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w[(r*K+c)*DW +: DW] = img[(wr+r)*W + wc + c];
        return w;
    endfunction

    function automatic int frame_bad(input int base);
        int bad = 0;
        if (win_log.size() - base != NW) bad++;
        for (int i = 0; i < NW && base + i < win_log.size(); i++)
            if (win_log[base+i] !== exp_window(i)) bad++;
        return bad;
    endfunction

    function automatic int addr_bad(input int base);
        int bad = 0;
        if (addr_log.size() - base != NPIX) bad++;
        for (int i = 0; i < NPIX && base + i < addr_log.size(); i++)
            if (addr_log[base+i] != i) bad++;
        return bad;
    endfunction

    task automatic fill_image(input bit rnd);
        for (int i = 0; i < NPIX; i++)
            img[i] = rnd ? DW'($urandom) : DW'(i / W + i % W);
    endtask

    task automatic set_bases();
        win_base   = win_log.size();
        addr_base  = addr_log.size();
        done_base  = done_cnt;
        stall_base = stall_err;
        valid_base = valid_cnt;
    endtask

    task automatic begin_frame();
        set_bases();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_frame(input bit rand_ready, input int restart_at, output bit timed_out);
        int n = 0;
        timed_out = 1'b1;
        while (n < 20000) begin
            if (done_cnt > done_base) begin
                timed_out = 1'b0;
                break;
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = (n == restart_at);
            @(posedge clk); #1;
            n++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({busy, done, enb, out_valid} !== 4'b0) begin errors++;
            $display("FAIL reset_ctrl: got busy/done/enb/valid=%b expected 0000", {busy, done, enb, out_valid}); end
        checks++; if (addrb !== '0) begin errors++;
            $display("FAIL reset_addrb: got %0d expected 0", addrb); end
        checks++; if (out_window !== '0) begin errors++;
            $display("FAIL reset_window: got %h expected 0", out_window); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        bit to;
        logic [WIN_W-1:0] w;
        fill_image(1'b0);
        out_ready = 1'b1;
        begin_frame();
        wait_frame(1'b0, -1, to);
        w = (win_log.size() > win_base) ? win_log[win_base] : '0;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: got done=0 expected done"); end
        checks++; if (first_enb_cyc - t_start != 1 || addr_log[addr_base] != 0) begin errors++;
            $display("FAIL basic_first_read: got phase %0d addr %0d expected phase 0 addr 0", first_enb_cyc - t_start - 1, addr_log[addr_base]); end
        checks++; if (first_valid_cyc - t_start != 119) begin errors++;
            $display("FAIL basic_first_valid: got after E%0d expected after E118", first_valid_cyc - t_start - 1); end
        checks++; if (w[0 +: DW] !== 8'd0 || w[24*DW +: DW] !== 8'd8 || w[4*DW +: DW] !== 8'd4) begin errors++;
            $display("FAIL basic_first_window: got (0,0)=%0d (4,4)=%0d (0,4)=%0d expected 0 8 4", w[0 +: DW], w[24*DW +: DW], w[4*DW +: DW]); end
        checks++; if (frame_bad(win_base) != 0) begin errors++;
            $display("FAIL basic_windows: got %0d bad of %0d (count %0d) expected 0 bad", frame_bad(win_base), NW, win_log.size() - win_base); end
        checks++; if (valid_cnt - valid_base != NW) begin errors++;
            $display("FAIL basic_valid_cycles: got %0d expected %0d", valid_cnt - valid_base, NW); end
        checks++; if (done_cyc - t_start != 787 || done_cnt - done_base != 1) begin errors++;
            $display("FAIL basic_done: got after E%0d count %0d expected after E786 count 1", done_cyc - t_start - 1, done_cnt - done_base); end
        checks++; if (busy_fall_cyc - t_start != 787) begin errors++;
            $display("FAIL basic_busy_low: got after E%0d expected after E786", busy_fall_cyc - t_start - 1); end
        checks++; if (addr_bad(addr_base) != 0) begin errors++;
            $display("FAIL basic_addr_seq: got %0d bad expected 0", addr_bad(addr_base)); end
    endtask

    task automatic test_random_ready();
        bit to;
        fill_image(1'b1);
        begin_frame();
        wait_frame(1'b1, -1, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL rand_timeout: got done=0 expected done"); end
        checks++; if (frame_bad(win_base) != 0) begin errors++;
            $display("FAIL rand_windows: got %0d bad (count %0d) expected 0 bad count %0d", frame_bad(win_base), win_log.size() - win_base, NW); end
        checks++; if (addr_bad(addr_base) != 0) begin errors++;
            $display("FAIL rand_addr_seq: got %0d bad expected 0", addr_bad(addr_base)); end
        checks++; if (stall_err != stall_base) begin errors++;
            $display("FAIL rand_stall_stable: got %0d violations expected 0", stall_err - stall_base); end
        checks++; if (done_cnt - done_base != 1) begin errors++;
            $display("FAIL rand_done_count: got %0d expected 1", done_cnt - done_base); end
    endtask

    task automatic test_stall();
        bit to;
        int n = 0;
        logic [WIN_W-1:0] w0;
        fill_image(1'b0);
        out_ready = 1'b1;
        begin_frame();
        while (!out_valid && n < 2000) begin @(posedge clk); #1; n++; end
        out_ready = 1'b0;
        w0 = out_window;
        checks++; if (out_valid !== 1'b1 || w0[0 +: DW] !== img[0]) begin errors++;
            $display("FAIL stall_first: got valid=%b (0,0)=%0d expected valid=1 (0,0)=%0d", out_valid, w0[0 +: DW], img[0]); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || out_window !== w0) begin errors++;
                $display("FAIL stall_hold_%0d: got valid=%b (0,0)=%0d expected valid=1 (0,0)=%0d", i, out_valid, out_window[0 +: DW], w0[0 +: DW]); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_window[0 +: DW] !== 8'd1) begin errors++;
            $display("FAIL stall_next: got valid=%b (0,0)=%0d expected valid=1 (0,0)=1", out_valid, out_window[0 +: DW]); end
        wait_frame(1'b0, -1, to);
        checks++; if (to !== 1'b0 || frame_bad(win_base) != 0) begin errors++;
            $display("FAIL stall_frame: got timeout=%b bad=%0d expected 0 0", to, frame_bad(win_base)); end
        checks++; if (addr_bad(addr_base) != 0 || stall_err != stall_base) begin errors++;
            $display("FAIL stall_addr_stable: got addr_bad=%0d stall_err=%0d expected 0 0", addr_bad(addr_base), stall_err - stall_base); end
    endtask

    task automatic test_start_while_busy();
        bit to;
        fill_image(1'b1);
        begin_frame();
        wait_frame(1'b0, 300, to);
        checks++; if (to !== 1'b0 || frame_bad(win_base) != 0) begin errors++;
            $display("FAIL restart_frame: got timeout=%b bad=%0d count=%0d expected 0 0 %0d", to, frame_bad(win_base), win_log.size() - win_base, NW); end
        checks++; if (done_cnt - done_base != 1 || done_cyc - t_start != 787) begin errors++;
            $display("FAIL restart_done: got count %0d after E%0d expected 1 after E786", done_cnt - done_base, done_cyc - t_start - 1); end
        checks++; if (addr_bad(addr_base) != 0) begin errors++;
            $display("FAIL restart_addr_seq: got %0d bad expected 0", addr_bad(addr_base)); end
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        fill_image(1'b0);
        out_ready = 1'b1;
        begin_frame();
        repeat (199) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if ({out_valid, busy, enb} !== 3'b000) begin errors++;
            $display("FAIL midrst_outputs: got valid/busy/enb=%b expected 000", {out_valid, busy, enb}); end
        fill_image(1'b1);
        begin_frame();
        wait_frame(1'b1, -1, to);
        checks++; if (to !== 1'b0 || frame_bad(win_base) != 0) begin errors++;
            $display("FAIL midrst_frame: got timeout=%b bad=%0d expected 0 0", to, frame_bad(win_base)); end
        checks++; if (addr_bad(addr_base) != 0) begin errors++;
            $display("FAIL midrst_addr_seq: got %0d bad expected 0", addr_bad(addr_base)); end
    endtask

    task automatic test_back_to_back();
        bit to;
        int n = 0;
        logic busy_before = 1'b0;
        fill_image(1'b1);
        out_ready = 1'b1;
        begin_frame();
        @(negedge clk);
        while (!done && n < 20000) begin
            busy_before = busy;
            @(negedge clk);
            n++;
        end
        checks++; if (done !== 1'b1 || busy_before !== 1'b1 || busy !== 1'b0) begin errors++;
            $display("FAIL b2b_first_end: got done=%b busy_before=%b busy=%b expected 1 1 0", done, busy_before, busy); end
        checks++; if (frame_bad(win_base) != 0) begin errors++;
            $display("FAIL b2b_frame1: got %0d bad expected 0", frame_bad(win_base)); end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++;
            $display("FAIL b2b_busy_gap: got busy=%b one cycle after done expected 1", busy); end
        set_bases();
        wait_frame(1'b0, -1, to);
        checks++; if (to !== 1'b0 || frame_bad(win_base) != 0) begin errors++;
            $display("FAIL b2b_frame2: got timeout=%b bad=%0d expected 0 0", to, frame_bad(win_base)); end
        checks++; if (first_valid_cyc - t_start != 119 || done_cyc - t_start != 787) begin errors++;
            $display("FAIL b2b_timing2: got valid after E%0d done after E%0d expected E118 E786", first_valid_cyc - t_start - 1, done_cyc - t_start - 1); end
        checks++; if (addr_bad(addr_base) != 0) begin errors++;
            $display("FAIL b2b_addr_seq2: got %0d bad expected 0", addr_bad(addr_base)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_ready();
        test_stall();
        test_start_while_busy();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
